copper_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the paired even/odd copper program memories.
- Drives the shared read address to both 16-bit halves and absorbs the one-cycle BRAM read latency.
- Concatenates the two halves into a 32-bit copper instruction and presents it to the copper execute stage over a valid/ready handshake.
- Buffers up to two instructions, sustains one instruction per clock, and flushes on jump, frame restart and disable.

---
 rtl/copper_fetch.sv | 165 ++++++++++++++++
 tb/tb_copper_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/copper_fetch.sv
// Copper instruction fetch: drives the paired even/odd memory address, absorbs the
// one-cycle read latency and hands 32-bit instructions to execute via valid/ready.
module copper_fetch #(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              cop_en_i,
  input  logic              restart_i,
  input  logic              jump_i,
  input  logic [AWIDTH-1:0] jump_addr_i,
  output logic [AWIDTH-1:0] rd_address_o,
  input  logic [15:0]       rd_data_even_i,
  input  logic [15:0]       rd_data_odd_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [AWIDTH-1:0] instr_addr_o
);

  localparam int unsigned IWIDTH = 32;
  localparam int unsigned OCCW   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [AWIDTH-1:0]   r_pc;
  logic                r_pend;
  logic [AWIDTH-1:0]   r_pend_addr;
  logic                r_out_valid;
  logic [IWIDTH-1:0]   r_out_data;
  logic [AWIDTH-1:0]   r_out_addr;
  logic                r_skid_valid;
  logic [IWIDTH-1:0]   r_skid_data;
  logic [AWIDTH-1:0]   r_skid_addr;

  logic                w_pop;
  logic [OCCW-1:0]     w_occ_after_pop;
  logic [OCCW-1:0]     w_load;
  logic                w_idle_hold;
  logic                w_flush;
  logic                w_issue;
  logic [AWIDTH-1:0]   w_pc_next;
  logic [IWIDTH-1:0]   w_rd_data;

  assign w_rd_data       = {rd_data_even_i, rd_data_odd_i};
  assign w_pop           = r_out_valid & instr_ready_i;
  assign w_occ_after_pop = OCCW'(r_out_valid) + OCCW'(r_skid_valid) - OCCW'(w_pop);
  // Entries that will be buffered after this edge, counting the read in flight.
  assign w_load          = w_occ_after_pop + OCCW'(r_pend);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and fetch control; flush sources in priority order.
  always_comb begin
    w_state_next = r_state;
    w_idle_hold  = 1'b0;
    w_flush      = 1'b0;
    w_issue      = 1'b0;
    w_pc_next    = r_pc;

    case (r_state)
      ST_IDLE: begin
        if (cop_en_i) begin
          w_state_next = ST_RUN;
        end else begin
          w_idle_hold = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cop_en_i) begin
          w_state_next = ST_IDLE;
          w_idle_hold  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idle_hold  = 1'b1;
      end
    endcase

    if (w_idle_hold) begin
      w_flush   = 1'b1;
      w_pc_next = '0;
    end else if (restart_i) begin
      w_flush   = 1'b1;
      w_pc_next = '0;
    end else if (jump_i) begin
      w_flush   = 1'b1;
      w_pc_next = jump_addr_i;
    end else if (w_load < OCCW'(2)) begin
      w_issue   = 1'b1;
      w_pc_next = r_pc + AWIDTH'(1);
    end
  end

  // Datapath: pc, pending read tracking, output register and skid entry.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_pc         <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_addr   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_addr  <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_flush) begin
        r_pend       <= 1'b0;
        r_out_valid  <= 1'b0;
        r_out_data   <= '0;
        r_out_addr   <= '0;
        r_skid_valid <= 1'b0;
      end else begin
        r_pend <= w_issue;
        if (w_issue) begin
          r_pend_addr <= r_pc;
        end
        if (!r_out_valid || w_pop) begin
          if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_addr   <= r_skid_addr;
            r_skid_valid <= r_pend;
            if (r_pend) begin
              r_skid_data <= w_rd_data;
              r_skid_addr <= r_pend_addr;
            end
          end else if (r_pend) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_data;
            r_out_addr  <= r_pend_addr;
          end else begin
            r_out_valid <= 1'b0;
          end
        end else if (r_pend) begin
          // Output held by a stall; issue gating guarantees the skid slot is free.
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_rd_data;
          r_skid_addr  <= r_pend_addr;
        end
      end
    end
  end

  assign rd_address_o  = r_pc;
  assign instr_valid_o = r_out_valid;
  assign instr_o       = r_out_data;
  assign instr_addr_o  = r_out_addr;

endmodule

// File: tb/tb_copper_fetch.sv
// Directed bench for copper_fetch: a registered memory model returns
// even=16'h1000+a, odd=16'h2000+a; each step samples outputs 1ns after posedge.
module tb_copper_fetch;

  localparam int unsigned AW = 10;

  logic          clk;
  logic          reset;
  logic          cop_en;
  logic          restart;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] rd_addr;
  logic [15:0]   even;
  logic [15:0]   odd;
  logic          valid;
  logic          ready;
  logic [31:0]   instr;
  logic [AW-1:0] iaddr;

  int n_chk  = 0;
  int n_pass = 0;

  copper_fetch #(.AWIDTH(AW)) dut (
    .clk           (clk),
    .reset_i       (reset),
    .cop_en_i      (cop_en),
    .restart_i     (restart),
    .jump_i        (jump),
    .jump_addr_i   (jump_addr),
    .rd_address_o  (rd_addr),
    .rd_data_even_i(even),
    .rd_data_odd_i (odd),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .instr_addr_o  (iaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory pair with one cycle of latency.
  always @(posedge clk) begin
    even <= 16'h1000 + 16'(rd_addr);
    odd  <= 16'h2000 + 16'(rd_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] exp_instr(input logic [AW-1:0] a);
    logic [15:0] e;
    logic [15:0] o;
    e = 16'h1000 + 16'(a);
    o = 16'h2000 + 16'(a);
    return {e, o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [AW-1:0] a);
    chk({tag, "/valid"}, 32'(valid), 32'd1);
    chk({tag, "/addr"},  32'(iaddr), 32'(a));
    chk({tag, "/instr"}, instr, exp_instr(a));
  endtask

  initial begin
    reset     = 1'b1;
    cop_en    = 1'b0;
    restart   = 1'b0;
    jump      = 1'b0;
    jump_addr = '0;
    ready     = 1'b0;
    step(); step(); step();
    chk("rst/valid", 32'(valid), 32'd0);
    chk("rst/instr", instr, 32'd0);
    chk("rst/iaddr", 32'(iaddr), 32'd0);
    chk("rst/rdaddr", 32'(rd_addr), 32'd0);

    reset = 1'b0;
    step();
    chk("idle/valid", 32'(valid), 32'd0);
    chk("idle/rdaddr", 32'(rd_addr), 32'd0);

    // Enable and stream.
    cop_en = 1'b1;
    ready  = 1'b1;
    step();
    chk("fill/valid", 32'(valid), 32'd0);
    chk("fill/rdaddr", 32'(rd_addr), 32'd1);
    step(); chk_out("s0", 10'd0);
    step(); chk_out("s1", 10'd1);
    step(); chk_out("s2", 10'd2);

    // Four-cycle stall while addr 2 is presented.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("stall", 10'd2);
      chk("stall/rdaddr", 32'(rd_addr), 32'd4);
      step();
    end
    ready = 1'b1;
    chk_out("resume2", 10'd2);
    step(); chk_out("resume3", 10'd3);
    step(); chk_out("resume4", 10'd4);
    step(); chk_out("resume5", 10'd5);

    // Fill output and skid, then jump.
    ready = 1'b0;
    step();
    chk_out("full", 10'd5);
    chk("full/rdaddr", 32'(rd_addr), 32'd7);
    jump      = 1'b1;
    jump_addr = 10'h155;
    step();
    jump  = 1'b0;
    ready = 1'b1;
    chk("jmp1/valid", 32'(valid), 32'd0);
    chk("jmp1/rdaddr", 32'(rd_addr), 32'h155);
    step();
    chk("jmp2/valid", 32'(valid), 32'd0);
    step(); chk_out("jmp3", 10'h155);
    step(); chk_out("jmp4", 10'h156);

    // Jump while a read is pending; address wrap.
    jump      = 1'b1;
    jump_addr = 10'h3FE;
    step();
    jump = 1'b0;
    chk("wrap1/valid", 32'(valid), 32'd0);
    chk("wrap1/rdaddr", 32'(rd_addr), 32'h3FE);
    step();
    chk("wrap2/valid", 32'(valid), 32'd0);
    step();
    chk_out("wrap3FE", 10'h3FE);
    chk("wrap/rdaddr", 32'(rd_addr), 32'd0);
    step(); chk_out("wrap3FF", 10'h3FF);
    step(); chk_out("wrap000", 10'h000);
    step(); chk_out("wrap001", 10'h001);

    // Restart and jump together during a stall: restart wins.
    ready = 1'b0;
    step();
    chk_out("rs/full", 10'h001);
    restart   = 1'b1;
    jump      = 1'b1;
    jump_addr = 10'h020;
    step();
    restart = 1'b0;
    jump    = 1'b0;
    ready   = 1'b1;
    chk("rs1/valid", 32'(valid), 32'd0);
    chk("rs1/rdaddr", 32'(rd_addr), 32'd0);
    step();
    chk("rs2/valid", 32'(valid), 32'd0);
    step(); chk_out("rs3", 10'd0);
    step(); chk_out("rs4", 10'd1);

    // Disable mid-stream, then re-enable.
    cop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis/valid", 32'(valid), 32'd0);
      chk("dis/rdaddr", 32'(rd_addr), 32'd0);
    end
    cop_en = 1'b1;
    step();
    chk("en1/valid", 32'(valid), 32'd0);
    chk("en1/rdaddr", 32'(rd_addr), 32'd1);
    step(); chk_out("en2", 10'd0);
    step(); chk_out("en3", 10'd1);

    // Reset mid-fetch.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst/valid", 32'(valid), 32'd0);
    chk("mrst/instr", instr, 32'd0);
    chk("mrst/iaddr", 32'(iaddr), 32'd0);
    chk("mrst/rdaddr", 32'(rd_addr), 32'd0);
    step();
    chk("mrst2/valid", 32'(valid), 32'd0);
    chk("mrst2/rdaddr", 32'(rd_addr), 32'd1);
    step(); chk_out("mrst3", 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
